// File: rtl/lsu_mem_req_sequencer_if.sv
// LSU memory request sequencer bus bundle.
// Op request, memory request and completion signals.
interface lsu_mem_req_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_rd;
  logic        req_wr;
  logic        req_gpr;
  logic [5:0]  req_cnt;
  logic [1:0]  req_depth;
  logic [31:0] req_base_addr;
  logic [5:0]  req_wfid;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_tag;
  logic        mem_ack;
  logic        done;
  logic [5:0]  done_wfid;
  logic        done_gpr;
  logic        done_err;
  logic        busy;

  modport master (
    output req_valid, req_rd, req_wr, req_gpr,
    output req_cnt, req_depth, req_base_addr, req_wfid,
    output mem_ack,
    input  req_ready, mem_rd_en, mem_wr_en,
    input  mem_addr, mem_tag,
    input  done, done_wfid, done_gpr, done_err, busy
  );

  modport slave (
    input  req_valid, req_rd, req_wr, req_gpr,
    input  req_cnt, req_depth, req_base_addr, req_wfid,
    input  mem_ack,
    output req_ready, mem_rd_en, mem_wr_en,
    output mem_addr, mem_tag,
    output done, done_wfid, done_gpr, done_err, busy
  );
endinterface

// File: rtl/lsu_mem_req_sequencer.sv
// LSU memory request sequencer.
// Expands one op into (depth+1)*(cnt+1) word requests.
module lsu_mem_req_sequencer (
  input  logic                      clk,
  input  logic                      rst,
  lsu_mem_req_sequencer_if.slave    bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  state;
  logic        rd;
  logic        wr;
  logic        gpr;
  logic        err;
  logic [5:0]  cnt;
  logic [1:0]  depth;
  logic [5:0]  wfid;
  logic [31:0] addr;
  logic [5:0]  word_idx;
  logic [1:0]  beat_idx;

  logic accept;
  logic last_word;

  assign accept    = (state == S_IDLE) && bus.req_valid;
  assign last_word = (word_idx == cnt);

  // Op sequencing: latch on accept, walk words/beats on each ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rd       <= 1'b0;
      wr       <= 1'b0;
      gpr      <= 1'b0;
      err      <= 1'b0;
      cnt      <= '0;
      depth    <= '0;
      wfid     <= '0;
      addr     <= '0;
      word_idx <= '0;
      beat_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            rd       <= bus.req_rd;
            wr       <= bus.req_wr;
            gpr      <= bus.req_gpr;
            cnt      <= bus.req_cnt;
            depth    <= bus.req_depth;
            wfid     <= bus.req_wfid;
            addr     <= bus.req_base_addr;
            word_idx <= '0;
            beat_idx <= '0;
            err      <= (bus.req_rd == bus.req_wr);
            state    <= (bus.req_rd ^ bus.req_wr)
                        ? S_ISSUE : S_DONE;
          end
        end
        S_ISSUE: begin
          if (bus.mem_ack) begin
            addr <= addr + 32'd4;
            if (last_word) begin
              word_idx <= '0;
              beat_idx <= beat_idx + 2'd1;
              if (beat_idx == depth)
                state <= S_DONE;
            end else begin
              word_idx <= word_idx + 6'd1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.mem_rd_en = (state == S_ISSUE) && rd;
  assign bus.mem_wr_en = (state == S_ISSUE) && wr;
  assign bus.mem_addr  = addr;
  assign bus.mem_tag   = {beat_idx, word_idx};
  assign bus.done      = (state == S_DONE);
  assign bus.done_err  = (state == S_DONE) && err;
  assign bus.done_wfid = wfid;
  assign bus.done_gpr  = gpr;

endmodule

// File: doc/lsu_mem_req_sequencer.md
LSU_MEM_REQ_SEQUENCER -- requirements
Module: lsu_mem_req_sequencer

Interface
REQ-001 SHALL have clk, input, 1: the single clock; all state updates on its rising edge.
REQ-002 SHALL have rst, input, 1: asynchronous, active-high reset.
REQ-003 SHALL have req_valid, input, 1: a decoded LSU memory op is offered.
REQ-004 SHALL have req_ready, output, 1: the block can accept an op this cycle.
REQ-005 SHALL have req_rd, input, 1: the op is a read; this is the decoder's mem_op_rd.
REQ-006 SHALL have req_wr, input, 1: the op is a write; this is the decoder's mem_op_wr.
REQ-007 SHALL have req_gpr, input, 1: the op targets SGPR (0) or VGPR (1).
REQ-008 SHALL have req_cnt, input, 6: words per beat minus 1 (0..63).
REQ-009 SHALL have req_depth, input, 2: beats minus 1 (0..3); this is gpr_op_depth.
REQ-010 SHALL have req_base_addr, input, 32: the byte address of the first word.
REQ-011 SHALL have req_wfid, input, 6: the issuing wavefront ID.
REQ-012 SHALL have mem_rd_en, output, 1: a read request is valid.
REQ-013 SHALL have mem_wr_en, output, 1: a write request is valid.
REQ-014 SHALL have mem_addr, output, 32: the request byte address.
REQ-015 SHALL have mem_tag, output, 8: {beat_idx[1:0], word_idx[5:0]} of the current request.
REQ-016 SHALL have mem_ack, input, 1: memory accepts the current request this cycle.
REQ-017 SHALL have done, output, 1: one-cycle pulse when the op completes.
REQ-018 SHALL have done_wfid, output, 6, and done_gpr, output, 1: the latched wfid and gpr of the completed op.
REQ-019 SHALL have done_err, output, 1: qualifies done; the op was malformed (rd == wr).
REQ-020 SHALL have busy, output, 1: high in any state other than IDLE.

Function
REQ-021 SHALL implement the states IDLE, ISSUE and DONE.
REQ-022 SHALL drive req_ready = 1 only in IDLE; an op is accepted when req_valid && req_ready.
REQ-023 SHALL, on acceptance, latch rd, wr, gpr, cnt, depth, wfid and base_addr, and clear word_idx and beat_idx to 0.
REQ-024 SHALL, on acceptance with exactly one of req_rd/req_wr set, go to ISSUE; otherwise it SHALL go to DONE with done_err = 1 and issue no memory request.
REQ-025 SHALL, in ISSUE, drive mem_rd_en = latched rd and mem_wr_en = latched wr, with mem_addr = the running address and mem_tag = {beat_idx, word_idx}.
REQ-026 SHALL hold the request and all its outputs stable until mem_ack; an ack in the same cycle the request first appears SHALL be honoured.
REQ-027 SHALL, on mem_ack, advance the running address by 4, wrapping modulo 2^32 without error.
REQ-028 SHALL, on mem_ack when word_idx < cnt, increment word_idx.
REQ-029 SHALL, on mem_ack when word_idx == cnt, set word_idx to 0 and increment beat_idx.
REQ-030 SHALL, on mem_ack when word_idx == cnt and beat_idx == depth, treat that request as last and go to DONE.
REQ-031 SHALL issue exactly (depth+1)*(cnt+1) requests per op, at most 256, with consecutive addresses.
REQ-032 SHALL, in DONE, assert done for exactly one cycle with done_wfid, done_gpr and done_err valid, then return to IDLE.
REQ-033 SHALL produce its first request in the cycle after acceptance, its done pulse in the cycle after the last ack, and req_ready = 1 in the cycle after done.
REQ-034 SHALL ignore mem_ack outside ISSUE.
REQ-035 SHALL ignore req_valid outside IDLE; the op is not consumed.
REQ-036 SHALL hold mem_rd_en = mem_wr_en = 0 outside ISSUE.
REQ-037 SHALL drive done_err = 0 whenever done = 0.

Reset
REQ-038 SHALL, on rst assertion, immediately enter IDLE.
REQ-039 SHALL hold req_ready = 1 while rst is asserted and coming out of reset.
REQ-040 SHALL drive mem_rd_en, mem_wr_en, done, done_err and busy to 0, and mem_addr, mem_tag, done_wfid, done_gpr and all counters to 0, on reset.
REQ-041 SHALL, on a reset in the middle of an op, abandon the op with no done pulse and no further requests.

Verification
REQ-042 SHALL cover: rd=1, cnt=0, depth=0, base=0x100, ack held high -> one read with addr 0x100 and tag 0x00; done at cycle 2 with err=0; req_ready at cycle 3.
REQ-043 SHALL cover: wr=1, cnt=63, depth=3, base=0x1000, ack always -> 256 writes at addresses 0x1000..0x13FC; last tag 0xFF; one done.
REQ-044 SHALL cover: rd=1, cnt=1, depth=1, ack every 3rd cycle -> 4 requests with tags 00, 01, 40, 41; each request held stable while ack is low.
REQ-045 SHALL cover: rd=wr=1 -> no mem_*_en, done=1 with done_err=1 one cycle after acceptance.
REQ-046 SHALL cover: base=0xFFFFFFF8, cnt=3, rd=1 -> addresses FFFFFFF8, FFFFFFFC, 00000000, 00000004.
REQ-047 SHALL cover: rst asserted after the 5th ack of a 64-word op -> outputs 0 asynchronously; no done; the next op starts cleanly at its own base_addr.
